// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared 8-bit instruction format constants, error codes and loader states
package cpu_isa_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_RSV0 = 3'b110;
    localparam logic [2:0] OP_RSV1 = 3'b111;
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 0;
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_RD   = 2'b01;
    localparam logic [1:0] ERR_OP   = 2'b10;
    localparam logic [1:0] ERR_OVF  = 2'b11;
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
endpackage

// File: rtl/inst_pack.sv
// inst_pack: packs decoded fields into an 8-bit word and flags illegal instructions
module inst_pack import cpu_isa_pkg::*; #(
    parameter bit STRICT = 1
) (
    input  logic [2:0] opcode,
    input  logic [2:0] rd,
    input  logic [2:0] rs,
    output logic [7:0] word,
    output logic       legal,
    output logic [1:0] code
);
    logic rsv;
    always_comb begin
        rsv = STRICT && (opcode == OP_RSV0 || opcode == OP_RSV1);
        code = rd[2] ? ERR_RD : rsv ? ERR_OP : ERR_NONE;
        legal = code == ERR_NONE;
        word = '0;
        word[OPC_MSB:OPC_LSB] = opcode;
        word[RD_MSB:RD_LSB] = rd[1:0];
        // NOT has no source operand; canonical form stores rs as zero
        word[RS_MSB:RS_LSB] = opcode == OP_NOT ? 3'b000 : rs;
    end
endmodule

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: validates and packs instruction beats, writing them to consecutive addresses
module inst_encoder_loader import cpu_isa_pkg::*; #(
    parameter int ADDR_W = 4,
    parameter bit STRICT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);
    state_t state;
    logic [7:0] word;
    logic       legal;
    logic [1:0] code;
    inst_pack #(.STRICT(STRICT)) u_pack (
        .opcode(in_opcode),
        .rd    (in_rd),
        .rs    (in_rs),
        .word  (word),
        .legal (legal),
        .code  (code)
    );
    assign in_ready = state == LOAD;
    assign busy = state == LOAD;
    // The next write address is the low bits of count; wrapping past the top is an overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            done <= 1'b0;
            err <= 1'b0;
            err_code <= ERR_NONE;
            count <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                state <= LOAD;
                done <= 1'b0;
                err <= 1'b0;
                err_code <= ERR_NONE;
                count <= '0;
            end else if (state == LOAD && in_valid) begin
                if (!legal) begin
                    state <= ERR;
                    err <= 1'b1;
                    err_code <= code;
                end else begin
                    mem_we <= 1'b1;
                    mem_addr <= count[ADDR_W-1:0];
                    mem_wdata <= word;
                    count <= count + 1'b1;
                    if (in_last) begin
                        state <= DONE;
                        done <= 1'b1;
                    end else if (&count[ADDR_W-1:0]) begin
                        state <= ERR;
                        err <= 1'b1;
                        err_code <= ERR_OVF;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb_inst_encoder_loader: directed checks of packing, legality, overflow, restart and round-trip
module tb_inst_encoder_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [2:0] in_opcode = '0;
    logic [2:0] in_rd = '0;
    logic [2:0] in_rs = '0;
    logic in_last = 1'b0;
    logic in_ready, mem_we, busy, done, err;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [1:0] err_code;
    logic [4:0] count;
    logic ns_ready, ns_we, ns_busy, ns_done, ns_err;
    logic [3:0] ns_addr;
    logic [7:0] ns_wdata;
    logic [1:0] ns_code;
    logic [4:0] ns_count;
    logic [7:0] mem [16];
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    inst_encoder_loader #(.ADDR_W(4), .STRICT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .count(count)
    );
    inst_encoder_loader #(.ADDR_W(4), .STRICT(0)) dut_ns (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ns_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_last(in_last),
        .mem_we(ns_we), .mem_addr(ns_addr), .mem_wdata(ns_wdata), .busy(ns_busy),
        .done(ns_done), .err(ns_err), .err_code(ns_code), .count(ns_count)
    );
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic beat(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic last);
        in_valid = 1'b1;
        in_opcode = op;
        in_rd = rd;
        in_rs = rs;
        in_last = last;
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    logic [2:0] r_op [10];
    logic [2:0] r_rd [10];
    logic [2:0] r_rs [10];
    initial begin
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 0);
        check("rst_flags", {mem_we, done, err, err_code}, 0);
        check("rst_count", count, 0);
        rst = 1'b0;
        // start in IDLE together with a valid beat: beat is not taken
        start = 1'b1;
        in_valid = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b0;
        check("idle_start_we", mem_we, 0);
        check("idle_start_cnt", count, 0);
        check("idle_start_busy", {busy, in_ready}, 2'b11);
        step();
        beat(3'b000, 3'd1, 3'd2, 1'b0);
        check("t1_w0", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd0, 8'h0A});
        beat(3'b001, 3'd3, 3'd7, 1'b0);
        check("t1_w1", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd1, 8'h3F});
        beat(3'b011, 3'd0, 3'd5, 1'b1);
        check("t1_w2", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd2, 8'h65});
        check("t1_done", {done, err, busy, in_ready}, 4'b1000);
        check("t1_count", count, 3);
        step();
        check("t1_hold", {mem_we, done, count}, {1'b0, 1'b1, 5'd3});
        pulse_start();
        check("t2_restart", {done, count, busy}, {1'b0, 5'd0, 1'b1});
        beat(3'b101, 3'd2, 3'd6, 1'b1);
        check("t2_not", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd0, 8'hB0});
        pulse_start();
        beat(3'b100, 3'd4, 3'd1, 1'b0);
        check("t3_rd_we", mem_we, 0);
        check("t3_rd_err", {err, err_code, done, busy}, {1'b1, 2'b01, 1'b0, 1'b0});
        pulse_start();
        check("t3_err_clr", {err, err_code}, 0);
        beat(3'b110, 3'd1, 3'd3, 1'b1);
        check("t3_op_err", {mem_we, err, err_code}, {1'b0, 1'b1, 2'b10});
        check("t3_ns_write", {ns_we, ns_wdata, ns_done, ns_err}, {1'b1, 8'hCB, 1'b1, 1'b0});
        pulse_start();
        beat(3'b111, 3'd5, 3'd0, 1'b0);
        check("t3_both", {mem_we, err, err_code}, {1'b0, 1'b1, 2'b01});
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            beat(3'(i % 6), 3'(i % 4), 3'(i % 8), 1'b0);
            check("t4_ovf_wr", {mem_we, mem_addr}, {1'b1, 4'(i)});
        end
        check("t4_ovf_err", {err, err_code, in_ready, done}, {1'b1, 2'b11, 1'b0, 1'b0});
        check("t4_ovf_cnt", count, 16);
        beat(3'b000, 3'd0, 3'd0, 1'b0);
        check("t4_ovf_nowr", {mem_we, count}, {1'b0, 5'd16});
        pulse_start();
        for (int i = 0; i < 16; i++) beat(3'(i % 6), 3'(i % 4), 3'(i % 8), i == 15);
        check("t4_full_done", {mem_we, mem_addr, done, err}, {1'b1, 4'd15, 1'b1, 1'b0});
        check("t4_full_cnt", count, 16);
        pulse_start();
        beat(3'b000, 3'd0, 3'd1, 1'b0);
        beat(3'b000, 3'd0, 3'd2, 1'b0);
        start = 1'b1;
        beat(3'b010, 3'd1, 3'd1, 1'b0);
        start = 1'b0;
        check("t5_abort", {mem_we, count, busy}, {1'b0, 5'd0, 1'b1});
        beat(3'b010, 3'd2, 3'd4, 1'b1);
        check("t5_restart_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd0, 8'h54});
        check("t5_restart_cnt", {count, done}, {5'd1, 1'b1});
        pulse_start();
        beat(3'b000, 3'd1, 3'd1, 1'b0);
        rst = 1'b1;
        beat(3'b000, 3'd1, 3'd1, 1'b0);
        check("t5_rst", {in_ready, busy, mem_we, mem_addr, mem_wdata, done, err, err_code, count}, 0);
        rst = 1'b0;
        step();
        check("t5_rst_idle", {in_ready, busy}, 0);
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            r_op[i] = 3'($urandom_range(0, 5));
            r_rd[i] = 3'($urandom_range(0, 3));
            r_rs[i] = 3'($urandom_range(0, 7));
            beat(r_op[i], r_rd[i], r_rs[i], i == 9);
        end
        step();
        check("t6_done", {done, count}, {1'b1, 5'd10});
        for (int i = 0; i < 10; i++) begin
            logic [7:0] w;
            w = mem[i];
            check("t6_op", w[7:5], r_op[i]);
            check("t6_rd", {1'b0, w[4:3]}, r_rd[i]);
            check("t6_rs", w[2:0], r_op[i] == 3'b101 ? 3'b000 : r_rs[i]);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
